// File: rtl/immediate_extractor.sv
// Registered RV32I immediate generator for decode.
// Classifies the opcode, extends the immediate, presents it one cycle later.
module immediate_extractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  output logic [31:0] imm,
  output logic [2:0]  imm_fmt,
  output logic        out_valid,
  output logic        illegal
);

  typedef enum logic [2:0] {
    F_NONE  = 3'd0,
    F_I     = 3'd1,
    F_S     = 3'd2,
    F_B     = 3'd3,
    F_U     = 3'd4,
    F_J     = 3'd5,
    F_SHAMT = 3'd6,
    F_ZIMM  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        sgn;
  fmt_e        fmt_d;
  logic        ill_d;
  logic [31:0] imm_d;

  assign op     = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign sgn    = instruction[31];

  always_comb begin
    fmt_d = F_NONE;
    ill_d = 1'b0;
    if (instruction[1:0] != 2'b11) begin
      ill_d = 1'b1;
    end else begin
      unique case (op)
        OP_LUI, OP_AUIPC:          fmt_d = F_U;
        OP_JAL:                    fmt_d = F_J;
        OP_JALR, OP_LOAD, OP_MISC: fmt_d = F_I;
        OP_IMM:
          fmt_d = (funct3[1:0] == 2'b01) ? F_SHAMT : F_I;
        OP_STORE:                  fmt_d = F_S;
        OP_BRANCH:                 fmt_d = F_B;
        OP_SYSTEM:
          fmt_d = funct3[2] ? F_ZIMM : F_I;
        OP_OP:                     fmt_d = F_NONE;
        default:                   ill_d = 1'b1;
      endcase
    end
  end

  // Pure bit selection; sign comes from instruction[31] in every format.
  always_comb begin
    imm_d = 32'b0;
    unique case (fmt_d)
      F_I:
        imm_d = {{20{sgn}}, instruction[31:20]};
      F_S:
        imm_d = {{20{sgn}}, instruction[31:25],
                 instruction[11:7]};
      F_B:
        imm_d = {{19{sgn}}, sgn, instruction[7],
                 instruction[30:25],
                 instruction[11:8], 1'b0};
      F_U:
        imm_d = {instruction[31:12], 12'b0};
      F_J:
        imm_d = {{11{sgn}}, sgn, instruction[19:12],
                 instruction[20], instruction[30:21],
                 1'b0};
      F_SHAMT:
        imm_d = {27'b0, instruction[24:20]};
      F_ZIMM:
        imm_d = {27'b0, instruction[19:15]};
      default:
        imm_d = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imm       <= 32'b0;
      imm_fmt   <= 3'd0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm     <= imm_d;
        imm_fmt <= fmt_d;
        illegal <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_immediate_extractor.sv
// Scoreboard bench for immediate_extractor.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_immediate_extractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] imm;
  logic [2:0]  imm_fmt;
  logic        out_valid;
  logic        illegal;

  typedef struct {
    logic        v;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    string       name;
  } exp_t;

  exp_t exq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] h_imm = '0;
  logic [2:0]  h_fmt = '0;
  logic        h_ill = 1'b0;

  immediate_extractor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .instruction(instruction),
    .imm        (imm),
    .imm_fmt    (imm_fmt),
    .out_valid  (out_valid),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic v, input logic [31:0] ei,
                      input logic [2:0] ef, input logic el,
                      input string nm);
    exp_t e;
    e.v = v; e.imm = ei; e.fmt = ef; e.ill = el; e.name = nm;
    exq.push_back(e);
  endtask

  task automatic send(input string nm, input logic [31:0] ins,
                      input logic [31:0] ei, input logic [2:0] ef,
                      input logic el);
    rst = 1'b0;
    in_valid = 1'b1;
    instruction = ins;
    @(posedge clk);
    h_imm = ei; h_fmt = ef; h_ill = el;
    push(1'b1, ei, ef, el, nm);
    #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] ins);
    rst = 1'b0;
    in_valid = 1'b0;
    instruction = ins;
    @(posedge clk);
    push(1'b0, h_imm, h_fmt, h_ill, nm);
    #1;
  endtask

  task automatic do_reset(input string nm, input logic v,
                          input logic [31:0] ins);
    rst = 1'b1;
    in_valid = v;
    instruction = ins;
    @(posedge clk);
    h_imm = '0; h_fmt = '0; h_ill = 1'b0;
    push(1'b0, 32'h0, 3'd0, 1'b0, nm);
    #1;
  endtask

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t e;
      e = exq.pop_front();
      cmp(e.name, "out_valid", {31'b0, out_valid}, {31'b0, e.v});
      cmp(e.name, "imm", imm, e.imm);
      cmp(e.name, "imm_fmt", {29'b0, imm_fmt}, {29'b0, e.fmt});
      cmp(e.name, "illegal", {31'b0, illegal}, {31'b0, e.ill});
    end else if (out_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out_valid actual=1 required=0");
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    instruction = '0;
    do_reset("reset0", 1'b0, 32'h0);
    do_reset("reset1", 1'b1, 32'hA000EC37);

    send("lui",    32'hA000EC37, 32'hA000E000, 3'd4, 1'b0);
    send("addi",   32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send("slli",   32'h00509093, 32'h00000005, 3'd6, 1'b0);
    send("sw_neg", 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    send("beq",    32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    send("jal8",   32'h0080006F, 32'h00000008, 3'd5, 1'b0);
    send("csrrwi", 32'h3002D073, 32'h00000005, 3'd7, 1'b0);
    send("zero",   32'h00000000, 32'h00000000, 3'd0, 1'b1);
    send("add",    32'h002081B3, 32'h00000000, 3'd0, 1'b0);

    send("auipc",  32'h12345017, 32'h12345000, 3'd4, 1'b0);
    send("jalr",   32'h800000E7, 32'hFFFFF800, 3'd1, 1'b0);
    send("lw",     32'h7FF00083, 32'h000007FF, 3'd1, 1'b0);
    send("fence",  32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0);
    send("srai",   32'h41F0D093, 32'h0000001F, 3'd6, 1'b0);
    send("csrrw",  32'h30001073, 32'h00000300, 3'd1, 1'b0);
    send("badop",  32'h0000007F, 32'h00000000, 3'd0, 1'b1);
    send("badlsb", 32'hFFF00091, 32'h00000000, 3'd0, 1'b1);
    send("jalm2",  32'hFFFFF06F, 32'hFFFFFFFE, 3'd5, 1'b0);
    send("bne800", 32'h000010E3, 32'h00000800, 3'd3, 1'b0);
    send("sw7ff",  32'h7E002FA3, 32'h000007FF, 3'd2, 1'b0);
    send("jalmid", 32'h000FF06F, 32'h000FF000, 3'd5, 1'b0);

    send("pre_hold", 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    idle("hold",   32'h0000007F);
    send("post_hold", 32'h00509093, 32'h00000005, 3'd6, 1'b0);
    do_reset("rst_valid", 1'b1, 32'hFFF00093);
    idle("hold_after_rst", 32'hA000EC37);
    send("after_rst", 32'hA000EC37, 32'hA000E000, 3'd4, 1'b0);
    idle("tail", 32'h0);

    for (int k = 0; k < 20 && exq.size() > 0; k++) @(posedge clk);
    if (exq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", exq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
